// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and encodings for the multi-cycle control unit
// Contents: state enum, opcode constants, ALU op codes, datapath mux encodings, state helper.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_JMP,
        S_JMPI,
        S_ALU_EX,
        S_ALU_WB,
        S_ALUI_EX,
        S_ALUI_WB,
        S_BR,
        S_ADDR,
        S_LD_MEM,
        S_LD_WB,
        S_ST_MEM,
        S_HALT,
        S_FAULT
    } state_e;

    localparam int OP_JMP  = 0;
    localparam int OP_JMPI = 1;
    localparam int OP_ALU  = 2;
    localparam int OP_ALUI = 3;
    localparam int OP_BR   = 4;
    localparam int OP_LD   = 5;
    localparam int OP_ST   = 6;
    localparam int OP_HALT = 7;

    localparam int ALU_ADD = 0;
    localparam int ALU_CMP = 1;

    localparam logic [1:0] PC_SEL_ALU = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_JMP = 2'b10;

    localparam logic [1:0] B_SEL_REG  = 2'b00;
    localparam logic [1:0] B_SEL_FOUR = 2'b01;
    localparam logic [1:0] B_SEL_IMM  = 2'b10;

    localparam logic [1:0] RW_SEL_RD  = 2'b00;
    localparam logic [1:0] RW_SEL_RT  = 2'b01;

    // States that hold mem_req and wait on mem_ready.
    function automatic logic is_mem_state(state_e s);
        return (s == S_FETCH) || (s == S_LD_MEM) || (s == S_ST_MEM);
    endfunction

endpackage

// File: rtl/ctrl_unit_mc_if.sv
// rtl/ctrl_unit_mc_if.sv - memory request/ready handshake between control unit and memory
// Signals: mem_req, memAdrSel, memWrCtl (controller -> memory), mem_ready (memory -> controller).
// Modports: master (controller side), slave (memory side).
interface ctrl_unit_mc_if;
    logic mem_req;
    logic mem_ready;
    logic memAdrSel;
    logic memWrCtl;

    modport master (output mem_req, output memAdrSel, output memWrCtl, input mem_ready);
    modport slave  (input mem_req, input memAdrSel, input memWrCtl, output mem_ready);
endinterface

// File: rtl/ctrl_mem_wait.sv
// rtl/ctrl_mem_wait.sv - memory wait-state counter with bounded timeout
// Ports: clk, reset (sync, active-high); in_mem (FSM is in a memory state), mem_ready;
//        wait_tmo (give up this cycle), wait_clr (counter clears this cycle).
module ctrl_mem_wait
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic in_mem,
    input  logic mem_ready,
    output logic wait_tmo,
    output logic wait_clr
);
    localparam int CW = $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Outside memory states the counter sits at zero, so every entry into a
    // memory state starts from zero without needing to detect the entry edge.
    always_comb begin
        wait_clr = !in_mem || mem_ready;
        wait_tmo = in_mem && !mem_ready && (cnt_q == CNT_LAST);
        cnt_d    = wait_clr ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/ctrl_unit_mc.sv
// rtl/ctrl_unit_mc.sv - multi-cycle control FSM with memory handshake, timeout and fault reporting
// Optional feature macro: CTRL_PERF_CNT_EN adds cyc_cnt/instr_cnt counters (PERF_W bits).
// Ports: clk, reset (sync, active-high); codop, alu_func, br_cond from IR/decoder/flags;
//        mem (master) memory handshake; ir_ld, pcWrSel, pcCtrl, aluOp, aluASel, aluBSel,
//        regWCtl, regDataSel, regWSel to datapath; halted, fault (sticky), illegal (pulse).
module ctrl_unit_mc
    import ctrl_pkg::*;
#(
    parameter int OPCODE_WIDTH  = 4,
    parameter int ALU_SEL_WIDTH = 4,
`ifdef CTRL_PERF_CNT_EN
    parameter int PERF_W        = 32,
`endif
    parameter int MEM_TIMEOUT   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [OPCODE_WIDTH-1:0]  codop,
    input  logic [ALU_SEL_WIDTH-1:0] alu_func,
    input  logic                     br_cond,
    ctrl_unit_mc_if.master           mem,
    output logic                     ir_ld,
    output logic [1:0]               pcWrSel,
    output logic                     pcCtrl,
    output logic [ALU_SEL_WIDTH-1:0] aluOp,
    output logic                     aluASel,
    output logic [1:0]               aluBSel,
    output logic                     regWCtl,
    output logic                     regDataSel,
    output logic [1:0]               regWSel,
    output logic                     halted,
    output logic                     fault,
`ifdef CTRL_PERF_CNT_EN
    output logic                     illegal,
    output logic [PERF_W-1:0]        cyc_cnt,
    output logic [PERF_W-1:0]        instr_cnt
`else
    output logic                     illegal
`endif
);
    state_e state_q, state_d;
    logic   wait_tmo, wait_clr;

    ctrl_mem_wait #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
        .clk       (clk),
        .reset     (reset),
        .in_mem    (is_mem_state(state_q)),
        .mem_ready (mem.mem_ready),
        .wait_tmo  (wait_tmo),
        .wait_clr  (wait_clr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // In a memory state wait_clr is exactly "access completes this cycle".
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   if (wait_clr) state_d = S_DECODE;
            S_DECODE: begin
                case (int'(codop))
                    OP_JMP:       state_d = S_JMP;
                    OP_JMPI:      state_d = S_JMPI;
                    OP_ALU:       state_d = S_ALU_EX;
                    OP_ALUI:      state_d = S_ALUI_EX;
                    OP_BR:        state_d = S_BR;
                    OP_LD, OP_ST: state_d = S_ADDR;
                    OP_HALT:      state_d = S_HALT;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_JMP, S_JMPI, S_ALU_WB, S_ALUI_WB, S_BR, S_LD_WB: state_d = S_FETCH;
            S_ALU_EX:  state_d = S_ALU_WB;
            S_ALUI_EX: state_d = S_ALUI_WB;
            S_ADDR:    state_d = (int'(codop) == OP_LD) ? S_LD_MEM : S_ST_MEM;
            S_LD_MEM:  if (wait_clr) state_d = S_LD_WB;
            S_ST_MEM:  if (wait_clr) state_d = S_FETCH;
            S_HALT, S_FAULT: state_d = state_q;
            default:   state_d = S_FETCH;
        endcase
        // Timeout is only raised when mem_ready is low, so a late ready still wins.
        if (wait_tmo) begin
            state_d = S_FAULT;
        end
    end

    // Outputs are forced to defaults while reset is held, which also drops
    // any outstanding memory request.
    always_comb begin
        mem.mem_req   = 1'b0;
        mem.memAdrSel = 1'b0;
        mem.memWrCtl  = 1'b0;
        ir_ld         = 1'b0;
        pcWrSel       = PC_SEL_ALU;
        pcCtrl        = 1'b0;
        aluOp         = ALU_SEL_WIDTH'(ALU_ADD);
        aluASel       = 1'b0;
        aluBSel       = B_SEL_REG;
        regWCtl       = 1'b0;
        regDataSel    = 1'b0;
        regWSel       = RW_SEL_RD;
        halted        = 1'b0;
        fault         = 1'b0;
        illegal       = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem.mem_req = 1'b1;
                    aluBSel     = B_SEL_FOUR;
                    pcCtrl      = mem.mem_ready;
                    ir_ld       = mem.mem_ready;
                end
                S_DECODE: begin
                    aluBSel = B_SEL_IMM;
                    illegal = (int'(codop) > OP_HALT);
                end
                S_JMP: begin
                    pcCtrl  = 1'b1;
                    pcWrSel = PC_SEL_JMP;
                end
                S_JMPI:    pcCtrl = 1'b1;
                S_ALU_EX, S_ALUI_EX: begin
                    aluOp   = alu_func;
                    aluASel = 1'b1;
                    aluBSel = (state_q == S_ALUI_EX) ? B_SEL_IMM : B_SEL_REG;
                end
                S_ALU_WB, S_ALUI_WB: begin
                    regWCtl    = 1'b1;
                    regDataSel = 1'b1;
                    regWSel    = (state_q == S_ALUI_WB) ? RW_SEL_RT : RW_SEL_RD;
                end
                S_BR: begin
                    aluOp   = ALU_SEL_WIDTH'(ALU_CMP);
                    aluASel = 1'b1;
                    pcWrSel = PC_SEL_BR;
                    pcCtrl  = br_cond;
                end
                S_ADDR: begin
                    aluASel = 1'b1;
                    aluBSel = B_SEL_IMM;
                end
                S_LD_MEM, S_ST_MEM: begin
                    mem.mem_req   = 1'b1;
                    mem.memAdrSel = 1'b1;
                    mem.memWrCtl  = (state_q == S_ST_MEM);
                end
                S_LD_WB: begin
                    regWCtl = 1'b1;
                    regWSel = RW_SEL_RT;
                end
                S_HALT:  halted = 1'b1;
                S_FAULT: fault  = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [PERF_W-1:0] cyc_cnt_q, cyc_cnt_d, instr_cnt_q, instr_cnt_d;
    logic              retire;

    // An instruction retires when it returns to FETCH from its last state;
    // illegal skips leave from DECODE and are therefore not counted.
    always_comb begin
        retire      = (state_d == S_FETCH) &&
                      (state_q inside {S_JMP, S_JMPI, S_ALU_WB, S_ALUI_WB, S_BR, S_LD_WB, S_ST_MEM});
        cyc_cnt_d   = cyc_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (state_q != S_HALT && state_q != S_FAULT) begin
            cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
        if (retire) begin
            instr_cnt_d = instr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt_q   <= '0;
            instr_cnt_q <= '0;
        end else begin
            cyc_cnt_q   <= cyc_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cyc_cnt   = cyc_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif
endmodule

// File: tb/tb_ctrl_unit_mc.sv
// tb/tb_ctrl_unit_mc.sv - self-checking bench for ctrl_unit_mc against an instruction-level model
module tb_ctrl_unit_mc;
    import ctrl_pkg::*;

    localparam int TMO = 16;

    typedef struct packed {
        logic       mem_req, ir_ld;
        logic [1:0] pc_wr_sel;
        logic       pc_ctrl, mem_adr_sel, mem_wr_ctl;
        logic [3:0] alu_op;
        logic       alu_a_sel;
        logic [1:0] alu_b_sel;
        logic       reg_w_ctl, reg_data_sel;
        logic [1:0] reg_w_sel;
        logic       halted, fault, illegal;
    } outv_t;

    typedef struct {
        logic [3:0] op;
        logic [3:0] fn;
        logic       bc;
        logic       rdy;
        outv_t      exp;
    } cyc_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] codop, alu_func, aluOp;
    logic       br_cond, ir_ld, pcCtrl, aluASel, regWCtl, regDataSel, halted, fault, illegal;
    logic [1:0] pcWrSel, aluBSel, regWSel;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cyc_cnt, instr_cnt;
`endif

    ctrl_unit_mc_if mif ();

    ctrl_unit_mc dut (
        .clk        (clk),
        .reset      (reset),
        .codop      (codop),
        .alu_func   (alu_func),
        .br_cond    (br_cond),
        .mem        (mif),
        .ir_ld      (ir_ld),
        .pcWrSel    (pcWrSel),
        .pcCtrl     (pcCtrl),
        .aluOp      (aluOp),
        .aluASel    (aluASel),
        .aluBSel    (aluBSel),
        .regWCtl    (regWCtl),
        .regDataSel (regDataSel),
        .regWSel    (regWSel),
        .halted     (halted),
        .fault      (fault),
`ifdef CTRL_PERF_CNT_EN
        .illegal    (illegal),
        .cyc_cnt    (cyc_cnt),
        .instr_cnt  (instr_cnt)
`else
        .illegal    (illegal)
`endif
    );

    always #5 clk = ~clk;

    int    cmp_cnt = 0;
    int    err_cnt = 0;
    cyc_t  q[$];
    outv_t obs[$];

    function automatic logic [3:0] rnd4();
        return 4'($urandom);
    endfunction

    function automatic logic rnd1();
        return 1'($urandom);
    endfunction

    function automatic outv_t o_def();
        outv_t o;
        o = '0;
        o.alu_op = 4'(ALU_ADD);
        return o;
    endfunction

    function automatic outv_t sample();
        outv_t s;
        s.mem_req      = mif.mem_req;
        s.ir_ld        = ir_ld;
        s.pc_wr_sel    = pcWrSel;
        s.pc_ctrl      = pcCtrl;
        s.mem_adr_sel  = mif.memAdrSel;
        s.mem_wr_ctl   = mif.memWrCtl;
        s.alu_op       = aluOp;
        s.alu_a_sel    = aluASel;
        s.alu_b_sel    = aluBSel;
        s.reg_w_ctl    = regWCtl;
        s.reg_data_sel = regDataSel;
        s.reg_w_sel    = regWSel;
        s.halted       = halted;
        s.fault        = fault;
        s.illegal      = illegal;
        return s;
    endfunction

    task automatic push(input logic [3:0] op, input logic [3:0] fn, input logic bc,
                        input logic rdy, input outv_t e);
        cyc_t c;
        c.op = op; c.fn = fn; c.bc = bc; c.rdy = rdy; c.exp = e;
        q.push_back(c);
    endtask

    // An access with 'waits' not-ready cycles; giving up after TMO of them.
    task automatic mem_phase(input logic [3:0] op, input outv_t wait_o, input outv_t done_o,
                             input int waits, output bit flt);
        flt = 1'b0;
        for (int k = 0; k < waits && !flt; k++) begin
            push(op, rnd4(), rnd1(), 1'b0, wait_o);
            if (k == TMO - 1) flt = 1'b1;
        end
        if (!flt) push(op, rnd4(), rnd1(), 1'b1, done_o);
    endtask

    task automatic tail_fault(input logic [3:0] op);
        outv_t o;
        o = o_def(); o.fault = 1'b1;
        repeat (5) push(op, rnd4(), rnd1(), rnd1(), o);
    endtask

    // Expected per-cycle outputs for one whole instruction, fetch included.
    task automatic instr(input logic [3:0] op, input logic [3:0] fn, input logic bc,
                         input int fwait, input int mwait);
        outv_t o, d;
        bit    flt;
        o = o_def(); o.mem_req = 1'b1; o.alu_b_sel = 2'b01;
        d = o; d.pc_ctrl = 1'b1; d.ir_ld = 1'b1;
        mem_phase(op, o, d, fwait, flt);
        if (flt) begin tail_fault(op); return; end
        o = o_def(); o.alu_b_sel = 2'b10; o.illegal = (op > 4'd7);
        push(op, rnd4(), rnd1(), rnd1(), o);
        if (op > 4'd7) return;
        case (op)
            4'd0, 4'd1: begin
                o = o_def(); o.pc_ctrl = 1'b1; o.pc_wr_sel = (op == 4'd0) ? 2'b10 : 2'b00;
                push(op, rnd4(), rnd1(), rnd1(), o);
            end
            4'd2, 4'd3: begin
                o = o_def(); o.alu_op = fn; o.alu_a_sel = 1'b1;
                o.alu_b_sel = (op == 4'd3) ? 2'b10 : 2'b00;
                push(op, fn, rnd1(), rnd1(), o);
                o = o_def(); o.reg_w_ctl = 1'b1; o.reg_data_sel = 1'b1;
                o.reg_w_sel = (op == 4'd3) ? 2'b01 : 2'b00;
                push(op, rnd4(), rnd1(), rnd1(), o);
            end
            4'd4: begin
                o = o_def(); o.alu_op = 4'(ALU_CMP); o.alu_a_sel = 1'b1;
                o.pc_wr_sel = 2'b01; o.pc_ctrl = bc;
                push(op, rnd4(), bc, rnd1(), o);
            end
            4'd5, 4'd6: begin
                o = o_def(); o.alu_a_sel = 1'b1; o.alu_b_sel = 2'b10;
                push(op, rnd4(), rnd1(), rnd1(), o);
                o = o_def(); o.mem_req = 1'b1; o.mem_adr_sel = 1'b1; o.mem_wr_ctl = (op == 4'd6);
                mem_phase(op, o, o, mwait, flt);
                if (flt) begin tail_fault(op); return; end
                if (op == 4'd5) begin
                    o = o_def(); o.reg_w_ctl = 1'b1; o.reg_w_sel = 2'b01;
                    push(op, rnd4(), rnd1(), rnd1(), o);
                end
            end
            default: begin
                o = o_def(); o.halted = 1'b1;
                repeat (20) push(op, rnd4(), rnd1(), rnd1(), o);
            end
        endcase
    endtask

    // Called at a falling edge; leaves at a falling edge.
    task automatic play();
        obs.delete();
        foreach (q[i]) begin
            codop = q[i].op; alu_func = q[i].fn; br_cond = q[i].bc; mif.mem_ready = q[i].rdy;
            #1;
            obs.push_back(sample());
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; mif.mem_ready = 1'b0; codop = '0; alu_func = '0; br_cond = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        outv_t e;
        reset = 1'b1; mif.mem_ready = 1'b1; codop = 4'd2; alu_func = 4'd9; br_cond = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            cmp_cnt++;
            if (sample() !== o_def()) begin
                err_cnt++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=%h", c, sample(), o_def());
            end
        end
        @(negedge clk);
        reset = 1'b0; mif.mem_ready = 1'b0;
        #1;
        e = o_def(); e.mem_req = 1'b1; e.alu_b_sel = 2'b01;
        cmp_cnt++;
        if (sample() !== e) begin
            err_cnt++;
            $display("FAIL reset_fetch got=%h exp=%h", sample(), e);
        end
        @(negedge clk);
    endtask

    task automatic test_alu();
        do_reset();
        instr(4'd2, 4'd5, 1'b0, 0, 0);
        instr(4'd3, 4'd12, 1'b0, 0, 0);
        instr(4'd1, 4'd0, 1'b0, 0, 0);
        play();
        foreach (q[i]) begin
            cmp_cnt++;
            if (obs[i] !== q[i].exp) begin
                err_cnt++;
                $display("FAIL alu cyc=%0d got=%h exp=%h", i, obs[i], q[i].exp);
            end
        end
        q.delete();
    endtask

    task automatic test_load_waits();
        do_reset();
        instr(4'd5, 4'd0, 1'b0, 2, 3);
        instr(4'd6, 4'd0, 1'b0, 0, 0);
        instr(4'd0, 4'd0, 1'b0, 0, 0);
        play();
        foreach (q[i]) begin
            cmp_cnt++;
            if (obs[i] !== q[i].exp) begin
                err_cnt++;
                $display("FAIL load cyc=%0d got=%h exp=%h", i, obs[i], q[i].exp);
            end
        end
        q.delete();
    endtask

    task automatic test_timeout();
        do_reset();
        instr(4'd6, 4'd0, 1'b0, 0, TMO);
        play();
        foreach (q[i]) begin
            cmp_cnt++;
            if (obs[i] !== q[i].exp) begin
                err_cnt++;
                $display("FAIL timeout_fault cyc=%0d got=%h exp=%h", i, obs[i], q[i].exp);
            end
        end
        q.delete();
        do_reset();
        instr(4'd6, 4'd0, 1'b0, 0, TMO - 1);
        instr(4'd5, 4'd0, 1'b0, TMO - 1, TMO - 1);
        instr(4'd1, 4'd0, 1'b0, 0, 0);
        play();
        foreach (q[i]) begin
            cmp_cnt++;
            if (obs[i] !== q[i].exp) begin
                err_cnt++;
                $display("FAIL timeout_late_ready cyc=%0d got=%h exp=%h", i, obs[i], q[i].exp);
            end
        end
        q.delete();
    endtask

    task automatic test_branch();
        do_reset();
        instr(4'd4, 4'd0, 1'b1, 0, 0);
        instr(4'd4, 4'd0, 1'b0, 1, 0);
        instr(4'd0, 4'd0, 1'b0, 0, 0);
        play();
        foreach (q[i]) begin
            cmp_cnt++;
            if (obs[i] !== q[i].exp) begin
                err_cnt++;
                $display("FAIL branch cyc=%0d got=%h exp=%h", i, obs[i], q[i].exp);
            end
        end
        q.delete();
    endtask

    task automatic test_illegal_halt();
        do_reset();
        instr(4'd9, 4'd0, 1'b0, 0, 0);
        instr(4'd15, 4'd0, 1'b0, 0, 0);
        instr(4'd1, 4'd0, 1'b0, 0, 0);
        instr(4'd7, 4'd0, 1'b0, 0, 0);
        play();
        foreach (q[i]) begin
            cmp_cnt++;
            if (obs[i] !== q[i].exp) begin
                err_cnt++;
                $display("FAIL illegal_halt cyc=%0d got=%h exp=%h", i, obs[i], q[i].exp);
            end
        end
        q.delete();
    endtask

    task automatic test_random();
        logic [3:0] op;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            do op = rnd4(); while (op == 4'd7);
            instr(op, rnd4(), rnd1(), $urandom_range(0, 3),
                  ($urandom_range(0, 7) == 0) ? TMO - 1 : $urandom_range(0, 4));
        end
        play();
        foreach (q[i]) begin
            cmp_cnt++;
            if (obs[i] !== q[i].exp) begin
                err_cnt++;
                $display("FAIL random cyc=%0d op=%0d got=%h exp=%h", i, q[i].op, obs[i], q[i].exp);
            end
        end
        q.delete();
    endtask

    initial begin
        reset = 1'b1; mif.mem_ready = 1'b0; codop = '0; alu_func = '0; br_cond = 1'b0;
        test_reset();
        test_alu();
        test_load_waits();
        test_timeout();
        test_branch();
        test_illegal_halt();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/ctrl_unit_mc.md
Name: ctrl_unit_mc

Overview:
- Parametrised multi-cycle control FSM for the core. It is the successor to the fixed-timing control unit.
- It adds a memory request/ready handshake with wait states and a bounded timeout, conditional branch resolution, and a per-instruction ALU function.
- It also adds HALT and illegal-opcode handling and sticky fault reporting.
- It sits between the instruction register/decoder and the datapath muxes (PC, memory address, ALU, register file).

Parameters:
- OPCODE_WIDTH, 4, width of codop; codes above OP_HALT are illegal.
- ALU_SEL_WIDTH, 4, width of aluOp and alu_func.
- MEM_TIMEOUT, 16, maximum cycles a memory state waits for mem_ready before FAULT; must be >= 2.
- PERF_W, 32, width of performance counters (optional feature only).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- codop  in  OPCODE_WIDTH  opcode field of the instruction register
- alu_func  in  ALU_SEL_WIDTH  ALU function field, used by ALU/ALUI
- br_cond  in  1  branch condition from ALU flags, valid in BR state
- mem_ready  in  1  memory completes the access this cycle
- mem_req  out  1  memory access request
- ir_ld  out  1  instruction register load strobe
- pcWrSel  out  2  PC source: 00 ALU result, 01 branch target, 10 jump target
- pcCtrl  out  1  PC write enable
- memAdrSel  out  1  0 PC, 1 ALU result
- memWrCtl  out  1  memory write
- aluOp  out  ALU_SEL_WIDTH  ALU operation
- aluASel  out  1  0 PC, 1 register A
- aluBSel  out  2  00 register B, 01 constant 4, 10 immediate
- regWCtl  out  1  register file write enable
- regDataSel  out  1  0 memory data, 1 ALU result
- regWSel  out  2  destination select: 00 rd, 01 rt
- halted  out  1  sticky, set on HALT
- fault  out  1  sticky, set on memory timeout
- illegal  out  1  one-cycle pulse in DECODE on an undefined opcode

Behaviour:
- Reset is synchronous, active-high, and applies on a clk edge.
  - State goes to FETCH and the wait counter clears.
  - halted and fault clear.
  - All combinational outputs take their defaults: 0, or ALU_ADD for aluOp.
- Reset mid-operation aborts any outstanding request. mem_req drops in the cycle after the reset edge.
- Outputs are Moore-style from state, except that pcCtrl and ir_ld in FETCH are qualified by mem_ready.
- Unlisted outputs hold their default in each state.
- States and outputs:
  - FETCH:
    - Outputs: mem_req=1, memAdrSel=0, aluASel=0, aluBSel=01, aluOp=ALU_ADD.
    - When mem_ready=1: pcCtrl=1, pcWrSel=00, ir_ld=1, next state DECODE.
    - Otherwise FETCH holds.
  - DECODE:
    - Outputs: aluOp=ALU_ADD, aluASel=0, aluBSel=10 (precompute target).
    - Next state by opcode: OP_JMP->JMP, OP_JMPI->JMPI, OP_ALU->ALU_EX, OP_ALUI->ALUI_EX, OP_BR->BR, OP_LD/OP_ST->ADDR, OP_HALT->HALT.
    - Any other opcode: illegal=1, next state FETCH (instruction skipped).
  - JMP: pcCtrl=1, pcWrSel=10, then FETCH.
  - JMPI: pcCtrl=1, pcWrSel=00, then FETCH.
  - ALU_EX: aluOp=alu_func, aluASel=1, aluBSel=00, then ALU_WB.
  - ALU_WB: regWCtl=1, regDataSel=1, regWSel=00, then FETCH.
  - ALUI_EX: aluOp=alu_func, aluASel=1, aluBSel=10, then ALUI_WB.
  - ALUI_WB: regWCtl=1, regDataSel=1, regWSel=01, then FETCH.
  - BR: aluOp=ALU_CMP, aluASel=1, aluBSel=00, pcWrSel=01, pcCtrl=br_cond, then FETCH.
  - ADDR: aluOp=ALU_ADD, aluASel=1, aluBSel=10, then LD_MEM if OP_LD, otherwise ST_MEM.
  - LD_MEM: mem_req=1, memAdrSel=1. Waits for mem_ready, then LD_WB.
  - LD_WB: regWCtl=1, regDataSel=0, regWSel=01, then FETCH.
  - ST_MEM: mem_req=1, memAdrSel=1, memWrCtl=1. Waits for mem_ready, then FETCH.
  - HALT: all outputs default, halted=1. Terminal until reset.
  - FAULT: all outputs default, fault=1. Terminal until reset.
- Wait counter:
  - Width is clog2(MEM_TIMEOUT).
  - Clears on entry to FETCH, LD_MEM and ST_MEM, and on mem_ready.
  - Increments each cycle in a memory state with mem_ready=0.
  - If mem_ready=0 while the counter equals MEM_TIMEOUT-1, next state is FAULT.
  - If mem_ready=1 arrives in that same cycle, it wins: normal transition, no fault.
- Handshake: mem_req stays asserted and the address and write select stay stable until the mem_ready cycle. There is no request in the cycle after completion unless the next state is itself a memory state.
- Unreachable state encodings go to FETCH.

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- When defined, adds two output ports:
  - cyc_cnt [PERF_W]: increments every cycle not in HALT/FAULT.
  - instr_cnt [PERF_W]: increments on each transition into FETCH from an execute/writeback/jump/branch/store state; illegal skips are not counted.
- Both counters clear on reset and wrap modulo 2^PERF_W.
- When undefined, neither the ports nor the counters exist. Behaviour is otherwise identical.

Decomposition:
- Package ctrl_pkg holds:
  - State enum.
  - Opcode constants: OP_JMP=0, OP_JMPI=1, OP_ALU=2, OP_ALUI=3, OP_BR=4, OP_LD=5, OP_ST=6, OP_HALT=7.
  - ALU_ADD and ALU_CMP.
  - Mux-select encodings for pcWrSel, aluBSel and regWSel.
- One sub-module: ctrl_mem_wait, containing the wait counter and timeout compare. Its outputs are the timeout and clear signals.

Test Plan:
- Reset: hold reset=1 for 2 cycles, then release -> state FETCH; mem_req=1, halted=0, fault=0, all write enables 0.
- ALU with no wait states: codop=2, alu_func=5, mem_ready=1 -> pcCtrl/ir_ld pulse in cycle 0, aluOp=5 in cycle 2, regWCtl=1/regWSel=00 in cycle 3, FETCH in cycle 4.
- Load with waits: codop=5, mem_ready low for 3 LD_MEM cycles -> memAdrSel=1 held 4 cycles, then LD_WB with regDataSel=0/regWSel=01.
- Timeout: ST_MEM with mem_ready=0 for MEM_TIMEOUT=16 cycles -> FAULT in cycle 17, fault=1 sticky. Repeat with mem_ready=1 at cycle 16 -> no fault.
- Branch: codop=4 with br_cond=1 -> pcCtrl=1/pcWrSel=01; with br_cond=0 -> pcCtrl=0. Both return to FETCH.
- Illegal/halt: codop=9 -> one-cycle illegal pulse, back to FETCH. codop=7 -> halted=1, mem_req stays 0 for 20 cycles.
